// File: rtl/init_multi_port_ram.sv
// Multi-port RAM with a self-initialising sweep. After reset or a clr
// request every entry is written with INIT_VALUE, one entry per clock;
// ready rises once the sweep completes and writes are accepted from then on.
module init_multi_port_ram #(
  parameter int unsigned ENTRY_NUM      = 16,
  parameter int unsigned ENTRY_BIT_SIZE = 32,
  parameter int unsigned READ_NUM       = 2,
  parameter int unsigned WRITE_NUM      = 2,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned BYPASS         = 0,
  parameter logic [ENTRY_BIT_SIZE-1:0] INIT_VALUE = '0,
  localparam int unsigned AW = $clog2(ENTRY_NUM)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     clr,
  input  logic [WRITE_NUM-1:0]                     we,
  input  logic [WRITE_NUM-1:0][AW-1:0]             wa,
  input  logic [WRITE_NUM-1:0][ENTRY_BIT_SIZE-1:0] wv,
  input  logic [READ_NUM-1:0][AW-1:0]              ra,
  output logic [READ_NUM-1:0][ENTRY_BIT_SIZE-1:0]  rv,
  output logic                                     ready
);

  typedef enum logic {INIT, READY} state_t;

  state_t        state, state_next;
  logic [AW-1:0] init_idx, init_idx_next;
  logic          wr_active;

  logic [ENTRY_BIT_SIZE-1:0] mem [ENTRY_NUM];

  logic [READ_NUM-1:0][ENTRY_BIT_SIZE-1:0] rd_data;
  logic [READ_NUM-1:0][ENTRY_BIT_SIZE-1:0] s1_data;
  logic [READ_NUM-1:0]                     s1_vld;

  assign ready     = (state == READY);
  assign wr_active = (state == READY) && !clr;

  // State and sweep-index register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      init_idx <= '0;
    end else begin
      state    <= state_next;
      init_idx <= init_idx_next;
    end
  end

  // Next-state logic: sweep entries, restart on clr
  always_comb begin
    state_next    = state;
    init_idx_next = init_idx;
    case (state)
      INIT: begin
        if (clr) begin
          init_idx_next = '0;
        end else if (init_idx == AW'(ENTRY_NUM - 1)) begin
          state_next    = READY;
          init_idx_next = '0;
        end else begin
          init_idx_next = init_idx + AW'(1);
        end
      end
      READY: begin
        if (clr) begin
          state_next    = INIT;
          init_idx_next = '0;
        end
      end
      default: begin
        state_next    = INIT;
        init_idx_next = '0;
      end
    endcase
  end

  // Storage writes; ascending port loop lets the highest port win a collision
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == INIT) begin
        mem[init_idx] <= INIT_VALUE;
      end else if (!clr) begin
        for (int unsigned i = 0; i < WRITE_NUM; i++) begin
          if (we[i]) mem[wa[i]] <= wv[i];
        end
      end
    end
  end

  // Array read with optional same-cycle write forwarding
  always_comb begin
    rd_data = '0;
    for (int unsigned j = 0; j < READ_NUM; j++) begin
      rd_data[j] = mem[ra[j]];
      if (BYPASS != 0 && wr_active) begin
        for (int unsigned i = 0; i < WRITE_NUM; i++) begin
          if (we[i] && wa[i] == ra[j]) rd_data[j] = wv[i];
        end
      end
    end
  end

  // First read stage: capture data and whether the read was issued while ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_data <= '0;
      s1_vld  <= '0;
    end else begin
      s1_data <= rd_data;
      s1_vld  <= {READ_NUM{ready}};
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [READ_NUM-1:0][ENTRY_BIT_SIZE-1:0] s2_data;
      logic [READ_NUM-1:0]                     s2_vld;

      // Output register stage
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s2_data <= '0;
          s2_vld  <= '0;
        end else begin
          s2_data <= s1_data;
          s2_vld  <= s1_vld;
        end
      end

      // Reads issued before ready present zero
      always_comb begin
        rv = '0;
        for (int unsigned j = 0; j < READ_NUM; j++) begin
          rv[j] = s2_vld[j] ? s2_data[j] : '0;
        end
      end
    end else begin : g_lat1
      // Reads issued before ready present zero
      always_comb begin
        rv = '0;
        for (int unsigned j = 0; j < READ_NUM; j++) begin
          rv[j] = s1_vld[j] ? s1_data[j] : '0;
        end
      end
    end
  endgenerate

endmodule
